// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared memory-port arbiter types and constants
package core_pkg;

    localparam int CORE_AW = 32;
    localparam int CORE_DW = 32;

    // Wide enough for any DW up to 1024; users slice the low DW/8 bits.
    localparam logic [127:0] MEM_BE_ALL = '1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/starve_ctr.sv
// rtl/starve_ctr.sv - saturating counter with synchronous clear and increment
module starve_ctr #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int AW         = CORE_AW,
    parameter int DW         = CORE_DW,
    parameter int MAX_STARVE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int SW = $clog2(MAX_STARVE + 1);

    arb_state_t    state;
    arb_state_t    state_next;
    logic          grant_i;
    logic          grant_d;
    logic          complete;
    logic          starved;
    logic [SW-1:0] starve_cnt;

    assign starved = (starve_cnt == SW'(MAX_STARVE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data side wins ties unless fetch has lost MAX_STARVE times in a row.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        complete   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (d_req && !(if_req && starved)) begin
                    grant_d    = 1'b1;
                    state_next = ARB_BUSY_D;
                end else if (if_req) begin
                    grant_i    = 1'b1;
                    state_next = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (mem_ack) begin
                    complete   = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    starve_ctr #(
        .MAX (MAX_STARVE),
        .W   (SW)
    ) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .clr (grant_i | (grant_d & ~if_req)),
        .inc (grant_d & if_req),
        .cnt (starve_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_gnt    <= grant_i;
            d_gnt     <= grant_d;
            if_rvalid <= complete && (state == ARB_BUSY_I);
            d_rvalid  <= complete && (state == ARB_BUSY_D);

            if (grant_i) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_be   <= MEM_BE_ALL[DW/8-1:0];
                mem_addr <= if_addr;
            end else if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_be    <= d_be;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (complete) begin
                mem_req <= 1'b0;
            end

            // Store completions also load d_rdata; the value is don't-care.
            if (complete && (state == ARB_BUSY_I)) begin
                if_rdata <= mem_rdata;
            end
            if (complete && (state == ARB_BUSY_D)) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;

    typedef struct {
        bit          i_side;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [1:0]  exp_gnt;
        bit          exp_we;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[6];

    mem_port_arbiter #(
        .AW         (32),
        .DW         (32),
        .MAX_STARVE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called at a negedge while IDLE; one complete single-requester transaction.
    task automatic run_txn(input vec_t v);
        if (v.i_side) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_be    = v.be;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end
        @(negedge clk);
        chk("gnt", {30'd0, if_gnt, d_gnt}, {30'd0, v.exp_gnt});
        chk("mem_req_at_gnt", {31'd0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_we_be", {27'd0, mem_we, mem_be}, {27'd0, v.exp_we, v.exp_be});
        if (!v.i_side) chk("mem_wdata", mem_wdata, v.wdata);
        if_req  = 1'b0;
        d_req   = 1'b0;
        if_addr = 32'hBAD0_0000;
        d_addr  = 32'hBAD0_0004;
        d_we    = ~d_we;
        d_be    = ~d_be;
        for (int j = 0; j <= v.delay; j++) begin
            if (j > 0) begin
                @(negedge clk);
                chk("busy_hold", {25'd0, mem_req, mem_we, mem_be, if_rvalid, d_rvalid},
                    {25'd0, 1'b1, v.exp_we, v.exp_be, 2'b00});
                chk("busy_addr", mem_addr, v.addr);
            end
            if (j == v.delay) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        if (v.i_side) exp_if_rdata = v.rdata;
        else          exp_d_rdata  = v.rdata;
        chk("rvalid", {30'd0, if_rvalid, d_rvalid}, {30'd0, v.exp_gnt});
        chk("done_mem_req_gnt", {29'd0, mem_req, if_gnt, d_gnt}, 32'd0);
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
    endtask

    // Called at a negedge while IDLE; holds the given requests, acks immediately.
    task automatic grant(input bit ireq, input bit dreq, output bit got_i);
        bit seen = 1'b0;
        if_req = ireq;
        d_req  = dreq;
        d_we   = 1'b0;
        got_i  = 1'b0;
        for (int n = 0; n < 4 && !seen; n++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) seen = 1'b1;
        end
        if (!seen) begin
            chk("gnt_timeout", 32'd0, 32'd1);
            return;
        end
        got_i = if_gnt;
        chk("one_gnt", {31'd0, if_gnt & d_gnt}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        if (got_i) exp_if_rdata = '0;
        else       exp_d_rdata  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_i;
        bit exp_order[10];

        vecs[0] = '{1'b1, 32'h0000_0040, 1'b0, 4'h0, 32'h0, 0, 32'h0000_0013, 2'b10, 1'b0, 4'hF};
        vecs[1] = '{1'b0, 32'h0000_0200, 1'b1, 4'b0011, 32'hDEAD_BEEF, 3, 32'h0000_0055, 2'b01, 1'b1, 4'b0011};
        vecs[2] = '{1'b0, 32'h0000_0300, 1'b0, 4'hF, 32'h0, 1, 32'hCAFE_F00D, 2'b01, 1'b0, 4'hF};
        vecs[3] = '{1'b1, 32'h0000_0044, 1'b0, 4'h0, 32'h0, 2, 32'h00A0_0093, 2'b10, 1'b0, 4'hF};
        vecs[4] = '{1'b0, 32'h0000_1FFC, 1'b0, 4'b0100, 32'h0, 0, 32'h1234_5678, 2'b01, 1'b0, 4'b0100};
        vecs[5] = '{1'b1, 32'h0000_0048, 1'b0, 4'h0, 32'h0, 1, 32'h0000_0073, 2'b10, 1'b0, 4'hF};

        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {27'd0, mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
        chk("reset_rdata", if_rdata | d_rdata, 32'd0);
        chk("reset_mem", mem_addr | mem_wdata | {27'd0, mem_we, mem_be}, 32'd0);
        rst = 1'b0;

        // Reset in the middle of a data load.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
        @(negedge clk);
        chk("rst_mid_gnt", {30'd0, d_gnt, mem_req}, 32'd3);
        chk("rst_mid_addr", mem_addr, 32'h100);
        d_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ctrl", {27'd0, mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_async_mem", mem_addr | {27'd0, mem_we, mem_be}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst_late_ack", {29'd0, mem_req, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_late_rdata", d_rdata | if_rdata, 32'd0);

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Spurious ack while idle.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("spur_ctrl", {27'd0, mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
        chk("spur_if_rdata", if_rdata, exp_if_rdata);
        chk("spur_d_rdata", d_rdata, exp_d_rdata);
        run_txn(vecs[0]);

        // Continuous contention: D,D,D,D,I repeated.
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int g = 0; g < 10; g++) begin
            grant(1'b1, 1'b1, got_i);
            chk($sformatf("starve_order_%0d", g), {31'd0, got_i}, {31'd0, exp_order[g]});
        end

        // Counter clears on an uncontended D grant.
        grant(1'b1, 1'b1, got_i);
        chk("clr_tie1", {31'd0, got_i}, 32'd0);
        grant(1'b1, 1'b1, got_i);
        chk("clr_tie2", {31'd0, got_i}, 32'd0);
        chk("clr_cnt2", 32'(dut.starve_cnt), 32'd2);
        grant(1'b0, 1'b1, got_i);
        chk("clr_solo", {31'd0, got_i}, 32'd0);
        chk("clr_cnt0", 32'(dut.starve_cnt), 32'd0);
        grant(1'b1, 1'b1, got_i);
        chk("clr_tie3", {31'd0, got_i}, 32'd0);
        chk("clr_cnt1", 32'(dut.starve_cnt), 32'd1);
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_idle", {29'd0, mem_req, if_gnt, d_gnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
